pipe_control: RTL and testbench
===============================

# pipe_control

Registered pipeline control unit for the LittleChip RISC-V core. It decodes the RV32I opcode at ID into a control bundle and carries that bundle through the EX, MEM and WB stage registers. It also detects load-use hazards, stalls decode, inserts bubbles, and honours branch flush and memory-stall requests. It replaces the single-cycle combinational opcode decoder; datapath muxes read only the per-stage outputs below.

## Interface
- `REG_AW`, default 5: register-index width.
- `LOAD_LAT`, default 1 (legal 1 or 2): number of cycles from MEM to load data; sets the length of a load-use stall.
- `clk` input, 1 bit: core clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `id_valid` input, 1 bit: instruction present at ID.
- `id_opcode` input, 7 bits: inst[6:0].
- `id_rd`, `id_rs1`, `id_rs2` inputs, REG_AW bits each: register fields.
- `mem_stall` input, 1 bit: freeze the entire pipe this cycle.
- `flush` input, 1 bit: branch or jump resolved taken in EX; kill the ID instruction.
- `id_ready` output, 1 bit: ID instruction accepted into EX this cycle.
- `id_illegal` output, 1 bit: unsupported opcode accepted; single-cycle pulse.
- `ex_valid` output, 1 bit: EX valid.
- `ex_alu_src` output, 2 bits: 00 = rs2, 01 = immediate, 10 = PC/imm (AUIPC, JAL, LUI).
- `ex_alu_op` output, 2 bits: 00 = add, 01 = branch compare, 10 = funct-decoded.
- `ex_branch` output, 1 bit: conditional branch.
- `ex_jump` output, 1 bit: JAL or JALR.
- `mem_valid`, `mem_read`, `mem_write` outputs, 1 bit each: MEM-stage controls.
- `wb_valid`, `wb_reg_write`, `wb_mem_to_reg` outputs, 1 bit each: WB-stage controls.
- `wb_rd` output, REG_AW bits: writeback index.
- Every output resets to 0.

## Operation
- Decode (combinational, ID):
  - LOAD: `reg_write`, `alu_src` 01, `alu_op` 00, `mem_read`, `mem_to_reg`.
  - STORE: `alu_src` 01, `mem_write`.
  - BRANCH: `alu_src` 00, `alu_op` 01, `branch`.
  - ARI_R: `reg_write`, `alu_src` 00, `alu_op` 10.
  - ARI_I: `reg_write`, `alu_src` 01, `alu_op` 10.
  - LUI, AUIPC: `reg_write`, `alu_src` 10, `alu_op` 00.
  - JAL: `reg_write`, `alu_src` 10, `jump`.
  - JALR: `reg_write`, `alu_src` 01, `jump`.
  - Any other opcode is illegal: `id_illegal` pulses and a bubble enters EX.
- `rd == 0` forces `reg_write` to 0.
- Source use:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by STORE, BRANCH and ARI_R.
- Hazard: `id_valid` is high, and a valid load in EX (or in MEM when LOAD_LAT = 2) has `rd != 0` equal to a used rs1 or rs2.
- Per-cycle priority:
  1. `mem_stall`: all stage registers hold; `id_ready` = 0.
  2. `flush`: EX loads a bubble; ID is killed, `id_ready` = 0; EX→MEM→WB advance normally.
  3. Hazard: EX loads a bubble; `id_ready` = 0; ID holds its instruction.
  4. Otherwise, EX loads the decoded bundle, qualified by `id_valid`.
- A bubble has valid = 0 and all control bits 0. A downstream stage never sees a control bit set while its valid is 0.
- `id_illegal` pulses only when the instruction is accepted, i.e. not under stall or flush.

## Timing
- Decode-to-EX latency: 1 cycle. EX→MEM: 1 cycle. MEM→WB: 1 cycle.
- Load-use stall length: LOAD_LAT cycles. After the stall, the dependent instruction enters EX.
- `id_ready` is combinational from the inputs and the current stage state.
- Reset is asynchronous assert with synchronous release. Reset mid-pipe clears all valids in the same edge-independent instant.
- `flush` and `mem_stall` together: the stall wins, and nothing moves. Upstream must hold `flush` until a cycle with `mem_stall` = 0.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - opcode constants (the existing `OPC_*` set);
  - `alu_src` and `alu_op` encodings;
  - the `ctrl_bundle_t` struct of the fields above.
- Sub-module `ctrl_decode`: the pure combinational opcode-to-bundle decoder, including the rs-use flags.
- The top level holds the stage registers, the hazard logic and the priority logic.

## Test plan
- Reset, then ARI_R with rd = 3: `ex_alu_op` = 10 after 1 cycle, then `mem_valid`, then `wb_reg_write` = 1 with `wb_rd` = 3. All outputs are 0 during reset.
- LOAD x5, immediately followed by ADD x6, x5, x1, with LOAD_LAT = 1: `id_ready` = 0 for 1 cycle, an EX bubble, then ADD in EX. With LOAD_LAT = 2: 2 stall cycles.
- LOAD x0, then an instruction using x0: no stall, and `wb_reg_write` = 0.
- BRANCH in EX with `flush` = 1 while STORE is at ID: STORE never asserts `mem_write`; the branch reaches MEM.
- `mem_stall` held 3 cycles during a mixed stream: all stage outputs frozen, then resume unchanged. `flush` + `mem_stall` together: no movement.
- Opcode 0x7F at ID: `id_illegal` pulses 1 cycle, the next EX is a bubble. Async `rst_n` low mid-stream: all valids 0 immediately.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I control definitions: opcodes, ALU encodings and the per-stage control bundle.
package riscv_ctrl_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_ARI_R  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ARI_I  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ALU_SRC_RS2 = 2'b00,
    ALU_SRC_IMM = 2'b01,
    ALU_SRC_PC  = 2'b10
  } alu_src_e;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_BRCMP = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic     reg_write;
    alu_src_e alu_src;
    alu_op_e  alu_op;
    logic     mem_read;
    logic     mem_write;
    logic     mem_to_reg;
    logic     branch;
    logic     jump;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_control_if.sv
// ID-side request/acceptance signals plus the per-stage control outputs of pipe_control.
interface pipe_control_if #(
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  logic [6:0]        id_opcode;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              mem_stall;
  logic              flush;

  logic              id_ready;
  logic              id_illegal;
  logic              ex_valid;
  logic [1:0]        ex_alu_src;
  logic [1:0]        ex_alu_op;
  logic              ex_branch;
  logic              ex_jump;
  logic              mem_valid;
  logic              mem_read;
  logic              mem_write;
  logic              wb_valid;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic [REG_AW-1:0] wb_rd;

  modport master (
    output id_valid, id_opcode, id_rd, id_rs1, id_rs2, mem_stall, flush,
    input  id_ready, id_illegal, ex_valid, ex_alu_src, ex_alu_op, ex_branch, ex_jump,
    input  mem_valid, mem_read, mem_write, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd
  );

  modport slave (
    input  id_valid, id_opcode, id_rd, id_rs1, id_rs2, mem_stall, flush,
    output id_ready, id_illegal, ex_valid, ex_alu_src, ex_alu_op, ex_branch, ex_jump,
    output mem_valid, mem_read, mem_write, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd
  );
endinterface

// File: rtl/ctrl_decode.sv
// Pure combinational RV32I opcode decoder: control bundle, illegal flag and source-register use.
module ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             rd_zero,
  output ctrl_bundle_t     ctrl_c,
  output logic             illegal_c,
  output logic             use_rs1_c,
  output logic             use_rs2_c
);

  always_comb begin
    ctrl_c    = CTRL_BUBBLE;
    illegal_c = 1'b0;
    use_rs1_c = 1'b1;
    use_rs2_c = 1'b0;

    unique case (opcode)
      OPC_LOAD: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.alu_src    = ALU_SRC_IMM;
        ctrl_c.alu_op     = ALU_OP_ADD;
        ctrl_c.mem_read   = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
      end
      OPC_STORE: begin
        ctrl_c.alu_src   = ALU_SRC_IMM;
        ctrl_c.mem_write = 1'b1;
        use_rs2_c        = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_c.alu_src = ALU_SRC_RS2;
        ctrl_c.alu_op  = ALU_OP_BRCMP;
        ctrl_c.branch  = 1'b1;
        use_rs2_c      = 1'b1;
      end
      OPC_ARI_R: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = ALU_SRC_RS2;
        ctrl_c.alu_op    = ALU_OP_FUNCT;
        use_rs2_c        = 1'b1;
      end
      OPC_ARI_I: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = ALU_SRC_IMM;
        ctrl_c.alu_op    = ALU_OP_FUNCT;
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = ALU_SRC_PC;
        ctrl_c.alu_op    = ALU_OP_ADD;
        use_rs1_c        = 1'b0;
      end
      OPC_JAL: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = ALU_SRC_PC;
        ctrl_c.jump      = 1'b1;
        use_rs1_c        = 1'b0;
      end
      OPC_JALR: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = ALU_SRC_IMM;
        ctrl_c.jump      = 1'b1;
      end
      default: begin
        illegal_c = 1'b1;
        use_rs1_c = 1'b0;
      end
    endcase

    // x0 is hardwired; never schedule a write to it
    if (rd_zero) ctrl_c.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control: ID decode into EX/MEM/WB control registers with load-use, flush and stall handling.
module pipe_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_control_if.slave  pif
);

  ctrl_bundle_t      dec_ctrl;
  logic              dec_illegal;
  logic              dec_use_rs1;
  logic              dec_use_rs2;

  ctrl_bundle_t      ex_ctrl_q;
  logic              ex_valid_q;
  logic [REG_AW-1:0] ex_rd_q;

  logic              mem_valid_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              mem_reg_write_q;
  logic              mem_to_reg_q;
  logic [REG_AW-1:0] mem_rd_q;

  logic              wb_valid_q;
  logic              wb_reg_write_q;
  logic              wb_mem_to_reg_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic              illegal_q;

  logic              ex_hit;
  logic              mem_hit;
  logic              hazard;
  logic              accept;
  logic              ex_valid_d;
  ctrl_bundle_t      ex_ctrl_d;
  logic [REG_AW-1:0] ex_rd_d;

  ctrl_decode u_decode (
    .opcode    (pif.id_opcode),
    .rd_zero   (pif.id_rd == '0),
    .ctrl_c    (dec_ctrl),
    .illegal_c (dec_illegal),
    .use_rs1_c (dec_use_rs1),
    .use_rs2_c (dec_use_rs2)
  );

  // Load in EX whose nonzero destination feeds a source the ID instruction reads
  assign ex_hit = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                  ((dec_use_rs1 && (ex_rd_q == pif.id_rs1)) ||
                   (dec_use_rs2 && (ex_rd_q == pif.id_rs2)));

  // Two-cycle loads keep the dependent instruction waiting while the load sits in MEM
  if (LOAD_LAT == 2) begin : g_lat2
    assign mem_hit = mem_valid_q && mem_read_q && (mem_rd_q != '0) &&
                     ((dec_use_rs1 && (mem_rd_q == pif.id_rs1)) ||
                      (dec_use_rs2 && (mem_rd_q == pif.id_rs2)));
  end else begin : g_lat1
    assign mem_hit = 1'b0;
  end

  // Priority: mem_stall, then flush, then load-use hazard, then normal issue
  always_comb begin
    hazard     = pif.id_valid && (ex_hit || mem_hit);
    accept     = pif.id_valid && !pif.mem_stall && !pif.flush && !hazard;
    ex_valid_d = accept && !dec_illegal;
    ex_ctrl_d  = CTRL_BUBBLE;
    ex_rd_d    = '0;
    if (ex_valid_d) begin
      ex_ctrl_d = dec_ctrl;
      ex_rd_d   = pif.id_rd;
    end
  end

  assign pif.id_ready = accept;

  // Stage registers; everything holds while memory stalls the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_ctrl_q       <= CTRL_BUBBLE;
      ex_rd_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      mem_rd_q        <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_q         <= '0;
      illegal_q       <= 1'b0;
    end else if (!pif.mem_stall) begin
      ex_valid_q      <= ex_valid_d;
      ex_ctrl_q       <= ex_ctrl_d;
      ex_rd_q         <= ex_rd_d;
      mem_valid_q     <= ex_valid_q;
      mem_read_q      <= ex_ctrl_q.mem_read;
      mem_write_q     <= ex_ctrl_q.mem_write;
      mem_reg_write_q <= ex_ctrl_q.reg_write;
      mem_to_reg_q    <= ex_ctrl_q.mem_to_reg;
      mem_rd_q        <= ex_rd_q;
      wb_valid_q      <= mem_valid_q;
      wb_reg_write_q  <= mem_reg_write_q;
      wb_mem_to_reg_q <= mem_to_reg_q;
      wb_rd_q         <= mem_rd_q;
      illegal_q       <= accept && dec_illegal;
    end else begin
      illegal_q       <= 1'b0;
    end
  end

  assign pif.id_illegal    = illegal_q;
  assign pif.ex_valid      = ex_valid_q;
  assign pif.ex_alu_src    = 2'(ex_ctrl_q.alu_src);
  assign pif.ex_alu_op     = 2'(ex_ctrl_q.alu_op);
  assign pif.ex_branch     = ex_ctrl_q.branch;
  assign pif.ex_jump       = ex_ctrl_q.jump;
  assign pif.mem_valid     = mem_valid_q;
  assign pif.mem_read      = mem_read_q;
  assign pif.mem_write     = mem_write_q;
  assign pif.wb_valid      = wb_valid_q;
  assign pif.wb_reg_write  = wb_reg_write_q;
  assign pif.wb_mem_to_reg = wb_mem_to_reg_q;
  assign pif.wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: one LOAD_LAT=1 instance and one LOAD_LAT=2 instance share stimulus.
module tb_pipe_control;
  import riscv_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pipe_control_if #(.REG_AW(5)) pif1 ();
  pipe_control_if #(.REG_AW(5)) pif2 ();

  pipe_control #(.REG_AW(5), .LOAD_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .pif(pif1.slave));
  pipe_control #(.REG_AW(5), .LOAD_LAT(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .pif(pif2.slave));

  assign pif2.id_valid  = pif1.id_valid;
  assign pif2.id_opcode = pif1.id_opcode;
  assign pif2.id_rd     = pif1.id_rd;
  assign pif2.id_rs1    = pif1.id_rs1;
  assign pif2.id_rs2    = pif1.id_rs2;
  assign pif2.mem_stall = pif1.mem_stall;
  assign pif2.flush     = pif1.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    pif1.id_valid  = v;
    pif1.id_opcode = opc;
    pif1.id_rd     = rd;
    pif1.id_rs1    = rs1;
    pif1.id_rs2    = rs2;
  endtask

  task automatic idle();
    drive(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    pif1.mem_stall = 1'b0;
    pif1.flush     = 1'b0;
    idle();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_id_ready", 32'(pif1.id_ready), 32'd0);
    chk("rst_id_illegal", 32'(pif1.id_illegal), 32'd0);
    chk("rst_ex_valid", 32'(pif1.ex_valid), 32'd0);
    chk("rst_mem_valid", 32'(pif1.mem_valid), 32'd0);
    chk("rst_wb_valid", 32'(pif1.wb_valid), 32'd0);
    chk("rst_wb_rd", 32'(pif1.wb_rd), 32'd0);
    rst_n = 1'b1;

    // ARI_R x3 flows EX -> MEM -> WB
    drive(1'b1, OPC_ARI_R, 5'd3, 5'd1, 5'd2);
    #1 chk("arir_id_ready", 32'(pif1.id_ready), 32'd1);
    step();
    chk("arir_ex_valid", 32'(pif1.ex_valid), 32'd1);
    chk("arir_ex_alu_op", 32'(pif1.ex_alu_op), 32'd2);
    chk("arir_ex_alu_src", 32'(pif1.ex_alu_src), 32'd0);
    idle();
    step();
    chk("arir_mem_valid", 32'(pif1.mem_valid), 32'd1);
    chk("arir_mem_read", 32'(pif1.mem_read), 32'd0);
    step();
    chk("arir_wb_valid", 32'(pif1.wb_valid), 32'd1);
    chk("arir_wb_reg_write", 32'(pif1.wb_reg_write), 32'd1);
    chk("arir_wb_rd", 32'(pif1.wb_rd), 32'd3);
    step();

    // LOAD x5 then ADD x6,x5,x1: one stall for LOAD_LAT=1, two for LOAD_LAT=2
    drive(1'b1, OPC_LOAD, 5'd5, 5'd1, 5'd0);
    #1 chk("ld_id_ready", 32'(pif1.id_ready), 32'd1);
    step();
    drive(1'b1, OPC_ARI_R, 5'd6, 5'd5, 5'd1);
    #1;
    chk("lu1_stall_ready", 32'(pif1.id_ready), 32'd0);
    chk("lu2_stall_ready", 32'(pif2.id_ready), 32'd0);
    step();
    chk("lu1_bubble", 32'(pif1.ex_valid), 32'd0);
    chk("lu1_mem_read", 32'(pif1.mem_read), 32'd1);
    chk("lu2_bubble", 32'(pif2.ex_valid), 32'd0);
    chk("lu1_ready_after", 32'(pif1.id_ready), 32'd1);
    chk("lu2_stall2_ready", 32'(pif2.id_ready), 32'd0);
    step();
    chk("lu1_add_ex_valid", 32'(pif1.ex_valid), 32'd1);
    chk("lu1_add_ex_alu_op", 32'(pif1.ex_alu_op), 32'd2);
    chk("lu1_ld_wb_m2r", 32'(pif1.wb_mem_to_reg), 32'd1);
    chk("lu1_ld_wb_rd", 32'(pif1.wb_rd), 32'd5);
    chk("lu2_bubble2", 32'(pif2.ex_valid), 32'd0);
    chk("lu2_ready_after", 32'(pif2.id_ready), 32'd1);
    step();
    chk("lu2_add_ex_valid", 32'(pif2.ex_valid), 32'd1);
    chk("lu2_add_ex_alu_op", 32'(pif2.ex_alu_op), 32'd2);
    idle();
    repeat (3) step();

    // LOAD x0 then a user of x0: no stall, no writeback
    drive(1'b1, OPC_LOAD, 5'd0, 5'd1, 5'd0);
    step();
    drive(1'b1, OPC_ARI_R, 5'd7, 5'd0, 5'd0);
    #1 chk("ldx0_no_stall", 32'(pif1.id_ready), 32'd1);
    step();
    chk("ldx0_add_ex", 32'(pif1.ex_valid), 32'd1);
    idle();
    step();
    chk("ldx0_wb_valid", 32'(pif1.wb_valid), 32'd1);
    chk("ldx0_wb_reg_write", 32'(pif1.wb_reg_write), 32'd0);
    repeat (2) step();

    // BRANCH in EX resolves taken while STORE waits at ID
    drive(1'b1, OPC_BRANCH, 5'd0, 5'd1, 5'd2);
    step();
    chk("br_ex_branch", 32'(pif1.ex_branch), 32'd1);
    chk("br_ex_alu_op", 32'(pif1.ex_alu_op), 32'd1);
    drive(1'b1, OPC_STORE, 5'd0, 5'd1, 5'd2);
    pif1.flush = 1'b1;
    #1 chk("fl_id_ready", 32'(pif1.id_ready), 32'd0);
    step();
    pif1.flush = 1'b0;
    idle();
    chk("fl_ex_bubble", 32'(pif1.ex_valid), 32'd0);
    chk("fl_br_in_mem", 32'(pif1.mem_valid), 32'd1);
    chk("fl_mem_write0", 32'(pif1.mem_write), 32'd0);
    step();
    chk("fl_mem_write1", 32'(pif1.mem_write), 32'd0);
    chk("fl_br_in_wb", 32'(pif1.wb_valid), 32'd1);
    repeat (2) step();

    // mem_stall for 3 cycles, then flush + mem_stall, then resume
    drive(1'b1, OPC_LOAD, 5'd8, 5'd2, 5'd0);
    step();
    drive(1'b1, OPC_ARI_I, 5'd9, 5'd3, 5'd0);
    step();
    drive(1'b1, OPC_STORE, 5'd0, 5'd4, 5'd5);
    pif1.mem_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) pif1.flush = 1'b1;
      #1 chk("st_id_ready", 32'(pif1.id_ready), 32'd0);
      step();
      chk("st_ex_valid", 32'(pif1.ex_valid), 32'd1);
      chk("st_ex_alu_src", 32'(pif1.ex_alu_src), 32'd1);
      chk("st_ex_alu_op", 32'(pif1.ex_alu_op), 32'd2);
      chk("st_mem_read", 32'(pif1.mem_read), 32'd1);
      chk("st_wb_valid", 32'(pif1.wb_valid), 32'd0);
    end
    pif1.mem_stall = 1'b0;
    pif1.flush     = 1'b0;
    #1 chk("rs_id_ready", 32'(pif1.id_ready), 32'd1);
    step();
    chk("rs_ex_alu_src", 32'(pif1.ex_alu_src), 32'd1);
    chk("rs_ex_alu_op", 32'(pif1.ex_alu_op), 32'd0);
    chk("rs_mem_read", 32'(pif1.mem_read), 32'd0);
    chk("rs_mem_valid", 32'(pif1.mem_valid), 32'd1);
    chk("rs_wb_m2r", 32'(pif1.wb_mem_to_reg), 32'd1);
    chk("rs_wb_rd", 32'(pif1.wb_rd), 32'd8);
    idle();
    step();
    chk("rs_store_mem_write", 32'(pif1.mem_write), 32'd1);
    repeat (3) step();

    // Illegal opcode: one-cycle pulse, bubble into EX
    drive(1'b1, 7'h7F, 5'd4, 5'd0, 5'd0);
    #1 chk("ill_id_ready", 32'(pif1.id_ready), 32'd1);
    step();
    idle();
    chk("ill_pulse", 32'(pif1.id_illegal), 32'd1);
    chk("ill_ex_bubble", 32'(pif1.ex_valid), 32'd0);
    step();
    chk("ill_pulse_end", 32'(pif1.id_illegal), 32'd0);
    chk("ill_mem_bubble", 32'(pif1.mem_valid), 32'd0);

    // Asynchronous reset mid-stream
    drive(1'b1, OPC_ARI_R, 5'd3, 5'd1, 5'd2);
    step();
    step();
    chk("ar_pre_ex_valid", 32'(pif1.ex_valid), 32'd1);
    chk("ar_pre_mem_valid", 32'(pif1.mem_valid), 32'd1);
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("ar_ex_valid", 32'(pif1.ex_valid), 32'd0);
    chk("ar_mem_valid", 32'(pif1.mem_valid), 32'd0);
    chk("ar_wb_valid", 32'(pif1.wb_valid), 32'd0);
    chk("ar_wb_rd", 32'(pif1.wb_rd), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
